// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ZERO   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_watchdog.sv
// Saturating cycle counter that flags when an operation has waited too long.
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiplier/divider: accept, start, wait under
// watchdog, commit to HI/LO, and stall MFHI/MFLO while busy.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] operand_b,
  output logic        op_ready,
  input  logic        abort,
  input  logic        read_hilo,
  output logic        mult_start,
  input  logic        mult_done,
  output logic        div_start,
  input  logic        div_done,
  output logic        hi_write,
  output logic        lo_write,
  output logic        busy,
  output logic        hilo_stall,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   wd_clear, wd_en, wd_expired;
  logic   sel_done;

  muldiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clear_i  (wd_clear),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  assign sel_done = (op_q == OP_DIV) ? div_done : mult_done;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wd_clear   = 1'b0;
    wd_en      = 1'b0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
    done       = 1'b0;
    div_zero   = 1'b0;
    timeout    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (op_valid && !abort) begin
          op_d    = op_is_div;
          state_d = (op_is_div == OP_DIV && operand_b == '0) ? ST_ZERO : ST_START;
        end
      end
      ST_ZERO: begin
        div_zero = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_START: begin
        mult_start = (op_q == OP_MULT);
        div_start  = (op_q == OP_DIV);
        wd_clear   = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        // A done arriving on the expiry cycle still commits.
        if (sel_done) begin
          state_d = ST_COMMIT;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        hi_write = 1'b1;
        lo_write = 1'b1;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides the transition only; this cycle's outputs still stand.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MULT;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // op_ready is masked by reset so every output reads 0 while reset is low.
  assign op_ready   = (state_q == ST_IDLE) && reset;
  assign busy       = (state_q != ST_IDLE);
  assign hilo_stall = read_hilo & busy;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; outputs are compared as one packed vector per cycle.
module tb_muldiv_ctrl;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        op_valid  = 1'b0;
  logic        op_is_div = 1'b0;
  logic [31:0] operand_b = '0;
  logic        abort     = 1'b0;
  logic        read_hilo = 1'b0;
  logic        mult_done = 1'b0;
  logic        div_done  = 1'b0;
  logic        op_ready, mult_start, div_start, hi_write, lo_write;
  logic        busy, hilo_stall, done, div_zero, timeout;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // {mult_start, div_start, hi_write, lo_write, done, div_zero, timeout, op_ready, busy, hilo_stall}
  logic [9:0] outs, exp_v;
  assign outs = {mult_start, div_start, hi_write, lo_write, done,
                 div_zero, timeout, op_ready, busy, hilo_stall};

  muldiv_ctrl #(
    .TIMEOUT_CYCLES(40),
    .CNT_W         (6)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_is_div (op_is_div),
    .operand_b (operand_b),
    .op_ready  (op_ready),
    .abort     (abort),
    .read_hilo (read_hilo),
    .mult_start(mult_start),
    .mult_done (mult_done),
    .div_start (div_start),
    .div_done  (div_done),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .busy      (busy),
    .hilo_stall(hilo_stall),
    .done      (done),
    .div_zero  (div_zero),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic is_div, input logic [31:0] b);
    op_valid  = 1'b1;
    op_is_div = is_div;
    operand_b = b;
  endtask

  task automatic test_reset();
    #2;
    reset     = 1'b0;
    op_valid  = 1'b1;
    op_is_div = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      exp_v = '0;
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
    op_valid = 1'b0;
    reset    = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) tick();
      exp_v = 10'b0000000100;
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
  endtask

  task automatic test_mult_with_stall();
    read_hilo = 1'b1;
    launch(1'b0, 32'd5);
    #1;
    exp_v = 10'b0000000100;
    n_checks++;
    if (outs !== exp_v) begin
      n_fail++;
      $display("FAIL mult cycle 0: got %b expected %b", outs, exp_v);
    end
    for (int c = 1; c <= 37; c++) begin
      tick();
      op_valid  = 1'b0;
      mult_done = (c == 34);
      #1;
      exp_v = {c == 1, 1'b0, c == 35, c == 35, c == 35, 1'b0, 1'b0,
               c >= 36, c <= 35, c <= 35};
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL mult cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
    mult_done = 1'b0;
    read_hilo = 1'b0;
  endtask

  task automatic test_back_to_back();
    launch(1'b0, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      op_valid = 1'b0;
      if (c == 4) launch(1'b1, 32'd0);
      mult_done = (c == 2);
      #1;
      exp_v = {c == 1, 1'b0, c == 3, c == 3, c == 3, c == 5, 1'b0,
               c == 4 || c == 6, c != 4 && c != 6, 1'b0};
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
    mult_done = 1'b0;
  endtask

  task automatic test_div_zero();
    launch(1'b1, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      op_valid = 1'b0;
      div_done = (c == 1);
      #1;
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c == 1, 1'b0, c >= 2, c == 1, 1'b0};
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL div_zero cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
    div_done = 1'b0;
  endtask

  task automatic test_timeout();
    launch(1'b1, 32'd7);
    for (int c = 1; c <= 43; c++) begin
      tick();
      op_valid = 1'b0;
      #1;
      exp_v = {1'b0, c == 1, 1'b0, 1'b0, 1'b0, 1'b0, c == 41, c >= 42, c <= 41, 1'b0};
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
    // Done arriving on the expiry cycle must commit instead of timing out.
    launch(1'b1, 32'd7);
    for (int c = 1; c <= 43; c++) begin
      tick();
      op_valid = 1'b0;
      div_done = (c == 41);
      #1;
      exp_v = {1'b0, c == 1, c == 42, c == 42, c == 42, 1'b0, 1'b0,
               c >= 43, c <= 42, 1'b0};
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL done_at_expiry cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
    div_done = 1'b0;
  endtask

  task automatic test_spurious_done();
    launch(1'b1, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      tick();
      op_valid  = 1'b0;
      div_done  = (c == 1) || (c == 8);
      mult_done = (c == 3) || (c == 5);
      #1;
      exp_v = {1'b0, c == 1, c == 9, c == 9, c == 9, 1'b0, 1'b0,
               c >= 10, c <= 9, 1'b0};
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL spurious_done cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
    div_done  = 1'b0;
    mult_done = 1'b0;
  endtask

  task automatic test_abort();
    launch(1'b0, 32'd9);
    for (int c = 1; c <= 45; c++) begin
      tick();
      op_valid  = (c == 12);
      abort     = (c == 10) || (c == 12);
      mult_done = (c == 14);
      #1;
      exp_v = {c == 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c >= 11, c <= 10, 1'b0};
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL abort cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
    abort     = 1'b0;
    op_valid  = 1'b0;
    mult_done = 1'b0;
  endtask

  task automatic test_reset_midop();
    read_hilo = 1'b1;
    launch(1'b0, 32'd1);
    for (int c = 1; c <= 50; c++) begin
      tick();
      op_valid  = 1'b0;
      reset     = !(c >= 6 && c <= 8);
      mult_done = (c == 7) || (c == 12) || (c == 34);
      #1;
      if (c >= 6 && c <= 8) begin
        exp_v = '0;
      end else begin
        exp_v = {c == 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c >= 9, c <= 5, c <= 5};
      end
      n_checks++;
      if (outs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_midop cycle %0d: got %b expected %b", c, outs, exp_v);
      end
    end
    mult_done = 1'b0;
    read_hilo = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult_with_stall();
    test_back_to_back();
    test_div_zero();
    test_timeout();
    test_spurious_done();
    test_abort();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the shared iterative multiplier and divider that feed the HI/LO registers of the multicycle CPU. It accepts one MULT/DIV request at a time from the main control unit, screens divide-by-zero, pulses the start input of the selected unit, and waits for its done flag under a watchdog. It then commits the result through hi_write/lo_write. It also stalls MFHI/MFLO while an operation is in flight.

## Interface
Parameters:
- TIMEOUT_CYCLES, 40: maximum WAIT cycles before abandoning an operation.
- CNT_W, 6: watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock, in, 1: single system clock. All state updates on the rising edge.
- reset, in, 1: asynchronous, active-low. Low forces all state and outputs to reset values immediately.
- op_valid, in, 1: control unit requests an operation.
- op_is_div, in, 1: 1 = DIV, 0 = MULT. Sampled at accept.
- operand_b, in, 32: divisor (B register). Sampled at accept.
- op_ready, out, 1: high only in IDLE.
- abort, in, 1: exception flush. Cancels any in-flight operation.
- read_hilo, in, 1: control unit is executing MFHI/MFLO.
- mult_start, out, 1: one-cycle start pulse to the multiplier.
- mult_done, in, 1: multiplier finished.
- div_start, out, 1: one-cycle start pulse to the divider.
- div_done, in, 1: divider finished.
- hi_write, out, 1: HI register load enable.
- lo_write, out, 1: LO register load enable.
- busy, out, 1: high in any state other than IDLE.
- hilo_stall, out, 1: read_hilo & busy, combinational.
- done, out, 1: one-cycle pulse on successful commit.
- div_zero, out, 1: one-cycle pulse on divide-by-zero.
- timeout, out, 1: one-cycle pulse on watchdog expiry.

## Operation
States: IDLE, ZERO, START, WAIT, COMMIT.
- IDLE → ZERO on accept (op_valid at edge) when op_is_div=1 and operand_b=0.
- IDLE → START on any other accept. The registered op_is_div selects the unit.
- ZERO: div_zero=1. No start pulse, no HI/LO write. Next state IDLE.
- START: the selected start output is 1, the other is 0. Counter cleared. Next state WAIT.
- WAIT: the counter increments by 1 each cycle and saturates.
  - Done of the selected unit → COMMIT.
  - Done of the non-selected unit is ignored.
  - Counter == TIMEOUT_CYCLES-1 with no done → IDLE, with timeout=1 in that same cycle and no write.
  - Done and expiry in the same cycle: done wins, go to COMMIT.
- COMMIT: hi_write=lo_write=1 and done=1 for exactly one cycle. Next state IDLE.
- Abort in any non-IDLE state: next state IDLE. The abort cycle itself still drives that state's outputs. No later done, write or timeout. Abort in IDLE has no effect, and an op_valid in the same cycle is not accepted.
- Start outputs are never asserted outside START.
- Done flags are ignored outside WAIT.
- Reset value of every output: 0.

## Timing
- Accept at edge 0. START occupies cycle 1. WAIT begins cycle 2.
- A done seen in WAIT cycle k gives COMMIT in cycle k+1. op_ready returns in cycle k+2.
- Minimum accept-to-commit is 3 cycles (done in the first WAIT cycle).
- Divide-by-zero: div_zero in cycle 1, op_ready in cycle 2.
- Timeout: the pulse occurs in WAIT cycle TIMEOUT_CYCLES. op_ready follows in the next cycle.
- hilo_stall is combinational, with no added latency. It is low in the cycle op_ready returns.
- Reset asserted mid-operation: immediate IDLE with all outputs 0. No write occurs after reset deasserts.

## Structure
- Shared package muldiv_pkg holds:
  - the state enum (3-bit encoding);
  - the op encoding constants OP_MULT=0 and OP_DIV=1.
- One sub-module, muldiv_watchdog: a CNT_W-bit counter with clear, enable, saturation, and an expired flag at TIMEOUT_CYCLES-1.
- The FSM, registered op select and output decode live in muldiv_ctrl.

## Test plan
- MULT, mult_done 33 cycles after mult_start → mult_start high only in cycle 1; hi_write/lo_write/done high in one cycle 35; op_ready in cycle 36.
- DIV with operand_b=0 → div_zero in cycle 1; div_start never high; no HI/LO write; op_ready in cycle 2.
- DIV with operand_b=7, div_done never asserted, TIMEOUT_CYCLES=40 → timeout pulse in cycle 41; no write; back to IDLE.
- DIV in flight with mult_done pulsed spuriously → ignored; commit only on div_done.
- abort in WAIT cycle 10 and reset pulled low mid-WAIT in a second run → IDLE; no done/write afterwards; all outputs 0 during reset.
- read_hilo held high during a MULT → hilo_stall high through COMMIT, low when op_ready rises.
